// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed MEM-stage data memory.
// Supports byte/half/word stores, sign/zero-extended loads, misalignment
// rejection and WAIT_STATES extra cycles per access behind a Ready stall.
// Optional macro DMEM_BOUNDS_CHECK_EN: reject addresses >= 4*DEPTH_WORDS
// and pulse AddrFault; when undefined addresses wrap and AddrFault stays 0.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  AccessSize,
    input  logic        LoadUnsigned,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Misaligned,
    output logic        AddrFault
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state, w_next_state;
    logic [3:0]  r_cnt, w_next_cnt;

    // Request captured at acceptance; BUSY-time input changes are ignored.
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_uns, r_wr;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept, w_commit;
    logic [31:0] w_c_addr, w_c_wdata;
    logic [1:0]  w_c_size;
    logic        w_c_uns, w_c_wr;
    logic        w_mis, w_oor, w_hi, w_reject, w_do_store;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep, w_word, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign Ready    = (r_state == S_IDLE);
    assign w_accept = Ready && (MemRead || MemWrite);

    // With no wait states the access commits straight from the live inputs
    // on the accepting edge; otherwise from the captured copy at the end of BUSY.
    assign w_commit  = ZERO_WAIT ? w_accept : ((r_state == S_BUSY) && (r_cnt == 4'd0));
    assign w_c_addr  = ZERO_WAIT ? Address      : r_addr;
    assign w_c_wdata = ZERO_WAIT ? WriteData    : r_wdata;
    assign w_c_size  = ZERO_WAIT ? AccessSize   : r_size;
    assign w_c_uns   = ZERO_WAIT ? LoadUnsigned : r_uns;
    assign w_c_wr    = ZERO_WAIT ? MemWrite     : r_wr;

    // Size 11 behaves as a word.
    assign w_mis = ((w_c_size == 2'b01) && w_c_addr[0]) ||
                   (w_c_size[1] && (w_c_addr[1:0] != 2'b00));
    assign w_hi  = |w_c_addr[31:AW+2];
`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oor = w_hi;
`else
    assign w_oor = 1'b0 & w_hi;
`endif
    assign w_reject   = w_mis || w_oor;
    assign w_idx      = w_c_addr[AW+1:2];
    assign w_do_store = w_commit && w_c_wr && !w_reject && !Rst;

    // Byte enables and lane-replicated store data (little-endian lanes).
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = w_c_wdata;
        case (w_c_size)
            2'b00: begin
                w_be        = 4'b0001 << w_c_addr[1:0];
                w_wdata_rep = {4{w_c_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_c_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{w_c_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = w_c_wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension.
    assign w_word = r_mem[w_idx];
    always_comb begin
        w_byte = w_word[8*w_c_addr[1:0] +: 8];
        w_half = w_c_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load = w_word;
        case (w_c_size)
            2'b00:   w_load = {{24{!w_c_uns && w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{!w_c_uns && w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Memory array: no reset, only addressed lanes are written.
    always_ff @(posedge Clk) begin
        if (w_do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

    // FSM state, wait counter and captured request.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr  <= Address;
                r_wdata <= WriteData;
                r_size  <= AccessSize;
                r_uns   <= LoadUnsigned;
                r_wr    <= MemWrite;
            end
        end
    end

    // Next-state: IDLE -> BUSY for WAIT_STATES cycles, back to IDLE on commit.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !ZERO_WAIT) begin
                    w_next_state = S_BUSY;
                    w_next_cnt   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) w_next_state = S_IDLE;
                else               w_next_cnt   = r_cnt - 4'd1;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs: load result holds unless a valid load commits.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ReadData   <= 32'd0;
            Misaligned <= 1'b0;
            AddrFault  <= 1'b0;
        end else begin
            Misaligned <= w_commit && w_mis;
            AddrFault  <= w_commit && w_oor;
            if (w_commit && !w_c_wr && !w_reject) ReadData <= w_load;
        end
    end

endmodule
